// File: rtl/piso_shift_tx.sv
// ---------------------------------------------------------------------------
// piso_shift_tx
//   Parallel-in / serial-out transmit shift register. A WIDTH-bit word is
//   accepted over a valid/ready handshake and sent one bit per enabled clock,
//   MSB-first or LSB-first. A new word can be accepted on the same edge that
//   retires the last bit of the previous one, so frames run back-to-back with
//   no gap. In circular mode the current word is repeated indefinitely.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   load_data   parallel word to transmit
//   load_valid  load_data is valid
//   load_ready  word accepted on an edge where load_valid && load_ready
//   dir         sampled at accept: 1 = MSB-first, 0 = LSB-first
//   en          shift enable; 0 stalls the frame
//   circular    sampled at the last bit: 1 = repeat the current word
//   sout        serial data bit
//   sout_valid  sout carries a frame bit
//   sof         high while the first bit of a word is on sout
//   last        high while bit WIDTH-1 of a word is on sout
//   done        one-cycle pulse after a frame ends and the block goes idle
// ---------------------------------------------------------------------------
module piso_shift_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             dir,
    input  logic             en,
    input  logic             circular,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             last,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic             dir_q;
    logic [CW-1:0]    cnt;

    logic             at_last;
    logic             accept;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] rotated;
    logic             rotated_bit;

    assign at_last  = (state == SHIFT) && (cnt == LAST_IDX);
    assign cnt_next = cnt + CW'(1);

    // Ready is combinational so a waiting word can be taken on the very edge
    // that consumes the last bit, giving zero-gap back-to-back frames.
    // It is forced low while reset is asserted.
    assign load_ready = rstn && ((state == IDLE) || (at_last && en));
    assign accept     = load_valid && load_ready;

    // The word register rotates rather than shifts: after WIDTH rotations it
    // holds the original word again, which is exactly what circular mode
    // needs without a second copy of the word.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        rotated     = shift_reg;
        rotated_bit = 1'b0;
        if (dir_q) begin
            rotated     = {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1]};
            rotated_bit = rotated[WIDTH-1];
        end else begin
            rotated     = {shift_reg[0], shift_reg[WIDTH-1:1]};
            rotated_bit = rotated[0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            shift_reg  <= '0;
            dir_q      <= 1'b0;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sof        <= 1'b0;
            last       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // New word: bit 0 of the frame goes straight onto sout.
                state      <= SHIFT;
                shift_reg  <= load_data;
                dir_q      <= dir;
                cnt        <= '0;
                sout       <= dir ? load_data[WIDTH-1] : load_data[0];
                sout_valid <= 1'b1;
                sof        <= 1'b1;
                last       <= 1'b0;
            end else if (state == SHIFT && en) begin
                if (at_last) begin
                    if (circular) begin
                        // Final rotation restores the original word, so the
                        // repeat starts from bit 0 in the stored direction.
                        shift_reg <= rotated;
                        cnt       <= '0;
                        sout      <= rotated_bit;
                        sof       <= 1'b1;
                        last      <= 1'b0;
                    end else begin
                        state      <= IDLE;
                        cnt        <= '0;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        sof        <= 1'b0;
                        last       <= 1'b0;
                        done       <= 1'b1;
                    end
                end else begin
                    shift_reg <= rotated;
                    cnt       <= cnt_next;
                    sout      <= rotated_bit;
                    sof       <= 1'b0;
                    last      <= (cnt_next == LAST_IDX);
                end
            end
            // en = 0 in SHIFT, or any cycle in IDLE: everything holds.
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_shift_tx
//   Directed bench for piso_shift_tx (WIDTH = 8). Stimulus pushes the
//   hand-computed serial sequence of each word into a scoreboard queue; a
//   monitor on the falling edge pops one entry per consumed bit (sout_valid
//   && en) or done pulse and compares it. Entries flagged contig must be
//   observed exactly one cycle after the previous pop.
// ---------------------------------------------------------------------------
module tb_piso_shift_tx;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rstn;
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             dir;
    logic             en;
    logic             circular;
    logic             sout;
    logic             sout_valid;
    logic             sof;
    logic             last;
    logic             done;

    piso_shift_tx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dir        (dir),
        .en         (en),
        .circular   (circular),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sof        (sof),
        .last       (last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        bit sout;
        bit sof;
        bit last;
        bit contig;
    } exp_t;

    exp_t sb[$];

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int last_pop  = -10;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_word(input logic [WIDTH-1:0] seq, input bit contig_first, input int stall_bit);
        exp_t it;
        for (int k = 0; k < WIDTH; k++) begin
            it.is_done = 1'b0;
            it.sout    = seq[WIDTH-1-k];
            it.sof     = (k == 0);
            it.last    = (k == WIDTH - 1);
            it.contig  = (k == 0) ? contig_first : (k != stall_bit);
            sb.push_back(it);
        end
    endtask

    task automatic push_done();
        exp_t it;
        it.is_done = 1'b1;
        it.sout    = 1'b0;
        it.sof     = 1'b0;
        it.last    = 1'b0;
        it.contig  = 1'b1;
        sb.push_back(it);
    endtask

    // Offer a word, wait (bounded) for acceptance, then confirm the
    // one-cycle accept-to-first-bit latency. dir is flipped afterwards to
    // show it only matters at accept.
    task automatic load_word(input logic [WIDTH-1:0] data, input logic d,
                             input logic [WIDTH-1:0] seq, input bit contig_first,
                             input int stall_bit);
        int n;
        push_word(seq, contig_first, stall_bit);
        load_data  = data;
        dir        = d;
        load_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!load_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) check("accept_timeout", 32'(load_ready), 32'd1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = ~data;
        dir        = ~d;
        check("first_bit_valid", 32'(sout_valid), 32'd1);
        check("first_bit_sof", 32'(sof), 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented bit; pops on consumption.
    always @(negedge clk) begin
        exp_t it;
        cyc++;
        if (rstn) begin
            if (sout_valid) begin
                check("load_ready_in_shift", 32'(load_ready), 32'(last && en));
                if (sb.size() == 0 || sb[0].is_done) begin
                    check("unexpected_bit", 32'(sout_valid), 32'd0);
                end else begin
                    it = sb[0];
                    check("sout", 32'(sout), 32'(it.sout));
                    check("sof", 32'(sof), 32'(it.sof));
                    check("last", 32'(last), 32'(it.last));
                    if (en) begin
                        if (it.contig) check("bit_contiguous", 32'(cyc), 32'(last_pop + 1));
                        void'(sb.pop_front());
                        last_pop = cyc;
                    end
                end
            end
            if (done) begin
                done_seen++;
                if (sb.size() == 0 || !sb[0].is_done) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    check("done_timing", 32'(cyc), 32'(last_pop + 1));
                    check("done_no_valid", 32'(sout_valid), 32'd0);
                    void'(sb.pop_front());
                    last_pop = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_last;
        int n;

        rstn       = 1'b0;
        load_data  = '0;
        load_valid = 1'b0;
        dir        = 1'b0;
        en         = 1'b1;
        circular   = 1'b0;
        #1;
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_sout_valid", 32'(sout_valid), 32'd0);
        check("rst_sof", 32'(sof), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        repeat (3) @(posedge clk);
        #3;
        rstn = 1'b1;
        #1;
        check("post_rst_load_ready", 32'(load_ready), 32'd1);

        // 1: 8'h1E MSB-first -> 0,0,0,1,1,1,1,0
        load_word(8'h1E, 1'b1, 8'b00011110, 1'b0, -1);
        push_done();
        wait_drain();

        // 2: 8'h1E LSB-first -> 0,1,1,1,1,0,0,0
        load_word(8'h1E, 1'b0, 8'b01111000, 1'b0, -1);
        push_done();
        wait_drain();

        // 3: 8'hA5 MSB-first -> 1,0,1,0,0,1,0,1 with 3-cycle stall on bit 3
        load_word(8'hA5, 1'b1, 8'b10100101, 1'b0, 3);
        repeat (3) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        push_done();
        wait_drain();

        // 4: 8'hFF then 8'h00 back-to-back, one done at the end
        load_word(8'hFF, 1'b1, 8'hFF, 1'b0, -1);
        load_word(8'h00, 1'b1, 8'h00, 1'b1, -1);
        push_done();
        wait_drain();

        // 5: 8'h81 repeated three times via circular
        circular = 1'b1;
        load_word(8'h81, 1'b1, 8'b10000001, 1'b0, -1);
        push_word(8'b10000001, 1'b1, -1);
        push_word(8'b10000001, 1'b1, -1);
        cnt_last = 0;
        n = 0;
        while (cnt_last < 2 && n < 100) begin
            @(negedge clk);
            if (last && en) cnt_last++;
            n++;
        end
        check("circular_last_seen", 32'(cnt_last), 32'd2);
        @(posedge clk);
        #1;
        circular = 1'b0;
        push_done();
        wait_drain();

        // 6: async reset at bit 4 of 8'h3C MSB-first (bit 4 = 1)
        load_word(8'h3C, 1'b1, 8'b00111100, 1'b0, -1);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_bit4", 32'(sout), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_sout", 32'(sout), 32'd0);
        check("async_rst_sout_valid", 32'(sout_valid), 32'd0);
        check("async_rst_last", 32'(last), 32'd0);
        check("async_rst_load_ready", 32'(load_ready), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        #1;
        check("rst_release_load_ready", 32'(load_ready), 32'd1);
        check("rst_no_done", 32'(done), 32'd0);
        // 8'h2D LSB-first -> 1,0,1,1,0,1,0,0
        load_word(8'h2D, 1'b0, 8'b10110100, 1'b0, -1);
        push_done();
        wait_drain();

        check("done_pulse_count", 32'(done_seen), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
